// File: rtl/serial_host_pkg.sv
// Shared types and constants for the serial peripheral host sequencer.
package serial_host_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        STAT_RD,
        STAT_W1,
        STAT_W2,
        DATA_WR,
        DATA_RD,
        DATA_W1,
        DATA_W2,
        DONE
    } state_t;

    // Status register bit positions
    localparam int unsigned ST_TX_OVW   = 0;
    localparam int unsigned ST_RX_OVW   = 1;
    localparam int unsigned ST_TX_RDY   = 2;
    localparam int unsigned ST_RX_RDY   = 3;
    localparam int unsigned ST_TX_EMPTY = 4;
    localparam int unsigned ST_RX_FULL  = 5;
    localparam int unsigned ST_BUSY     = 7;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    localparam int unsigned READ_LAT = 2;

endpackage

// File: rtl/serial_host_ctrl_rr_arb2.sv
// Two-client round-robin arbiter; the priority pointer moves past the client
// whose transaction just completed.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_done,
    input  logic       i_done_idx,
    output logic       o_gnt_c,
    output logic       o_valid_c
);

    logic r_prio;

    always_comb begin
        o_valid_c = |i_req;
        o_gnt_c   = i_req[r_prio] ? r_prio : ~r_prio;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= 1'b0;
        end else if (i_done) begin
            r_prio <= ~i_done_idx;
        end
    end

endmodule

// File: rtl/serial_host_ctrl.sv
// Register-bus sequencer for the buffered serial peripheral: arbitrates two byte
// clients, polls status until ready, then moves exactly one byte.
module serial_host_ctrl
    import serial_host_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        op,
    input  logic [BYTE_W-1:0] wdata0,
    input  logic [BYTE_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic              timeout,
    output logic [BYTE_W-1:0] rdata,
    output logic              ser_A,
    output logic              ser_CE,
    output logic              ser_WREN,
    output logic              ser_REN,
    output logic [BYTE_W-1:0] ser_wdata,
    input  logic [BYTE_W-1:0] ser_rdata,
    output logic              err_tx_ovw,
    output logic              err_rx_ovw,
    input  logic              err_clr
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_gnt;
    logic              r_op;
    logic [BYTE_W-1:0] r_wbyte;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_to_hit;
    logic              w_ce_n;
    logic              w_ren_n;
    logic              w_wren_n;
    logic              w_a_n;
    logic              w_gnt;
    logic              w_gnt_valid;
    logic              w_done;
    logic              w_sample;

    logic [1:0]        r_ack;
    logic              r_timeout;
    logic [BYTE_W-1:0] r_rdata;
    logic              r_ser_A;
    logic              r_ser_CE;
    logic              r_ser_WREN;
    logic              r_ser_REN;
    logic [BYTE_W-1:0] r_ser_wdata;
    logic              r_err_tx;
    logic              r_err_rx;

    assign w_done   = (r_state == DONE);
    assign w_sample = (r_state == STAT_W2);

    rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (req),
        .i_done     (w_done),
        .i_done_idx (r_gnt),
        .o_gnt_c    (w_gnt),
        .o_valid_c  (w_gnt_valid)
    );

    // Next state plus the bus strobes of that next state, so outputs register in step
    always_comb begin
        w_state_next = r_state;
        w_to_hit     = 1'b0;
        w_cnt_inc    = r_cnt + CNT_W'(1);
        w_ce_n       = 1'b0;
        w_ren_n      = 1'b0;
        w_wren_n     = 1'b0;
        w_a_n        = 1'b1;

        unique case (r_state)
            IDLE:    if (w_gnt_valid) w_state_next = STAT_RD;
            STAT_RD: w_state_next = STAT_W1;
            STAT_W1: w_state_next = STAT_W2;
            STAT_W2: begin
                if (r_op == OP_WR && ser_rdata[ST_TX_RDY]) begin
                    w_state_next = DATA_WR;
                end else if (r_op == OP_RD && ser_rdata[ST_RX_RDY]) begin
                    w_state_next = DATA_RD;
                end else if (w_cnt_inc == CNT_W'(POLL_LIMIT)) begin
                    w_state_next = DONE;
                    w_to_hit     = 1'b1;
                end else begin
                    w_state_next = STAT_RD;
                end
            end
            DATA_WR: w_state_next = DONE;
            DATA_RD: w_state_next = DATA_W1;
            DATA_W1: w_state_next = DATA_W2;
            DATA_W2: w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            STAT_RD: begin
                w_ce_n  = 1'b1;
                w_ren_n = 1'b1;
            end
            DATA_WR: begin
                w_ce_n   = 1'b1;
                w_wren_n = 1'b1;
                w_a_n    = 1'b0;
            end
            DATA_RD: begin
                w_ce_n  = 1'b1;
                w_ren_n = 1'b1;
                w_a_n   = 1'b0;
            end
            DATA_W1, DATA_W2: w_a_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= 1'b0;
            r_op        <= OP_WR;
            r_wbyte     <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_timeout   <= 1'b0;
            r_rdata     <= '0;
            r_ser_A     <= 1'b1;
            r_ser_CE    <= 1'b0;
            r_ser_WREN  <= 1'b0;
            r_ser_REN   <= 1'b0;
            r_ser_wdata <= '0;
            r_err_tx    <= 1'b0;
            r_err_rx    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ser_A     <= w_a_n;
            r_ser_CE    <= w_ce_n;
            r_ser_WREN  <= w_wren_n;
            r_ser_REN   <= w_ren_n;
            r_ser_wdata <= (w_state_next == DATA_WR) ? r_wbyte : '0;
            r_ack       <= (w_state_next == DONE) ? {r_gnt, ~r_gnt} : 2'b00;
            r_timeout   <= w_to_hit;

            if (r_state == IDLE && w_gnt_valid) begin
                r_gnt   <= w_gnt;
                r_op    <= op[w_gnt];
                r_wbyte <= w_gnt ? wdata1 : wdata0;
                r_cnt   <= '0;
            end
            if (w_sample) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == DATA_W2) begin
                r_rdata <= ser_rdata;
            end

            // A fresh status sample takes precedence over a simultaneous clear
            r_err_tx <= (r_err_tx & ~err_clr) | (w_sample & ser_rdata[ST_TX_OVW]);
            r_err_rx <= (r_err_rx & ~err_clr) | (w_sample & ser_rdata[ST_RX_OVW]);
        end
    end

    assign ack        = r_ack;
    assign timeout    = r_timeout;
    assign rdata      = r_rdata;
    assign ser_A      = r_ser_A;
    assign ser_CE     = r_ser_CE;
    assign ser_WREN   = r_ser_WREN;
    assign ser_REN    = r_ser_REN;
    assign ser_wdata  = r_ser_wdata;
    assign err_tx_ovw = r_err_tx;
    assign err_rx_ovw = r_err_rx;

endmodule

// File: tb/tb_serial_host_ctrl.sv
// Scoreboard bench for serial_host_ctrl with a 2-cycle-latency peripheral model.
module tb_serial_host_ctrl;
    import serial_host_pkg::*;

    localparam int unsigned POLL   = 3;
    localparam int          WR_LAT = 5;
    localparam int          RD_LAT = 5 + int'(READ_LAT);
    localparam int          TO_LAT = 1 + 3 * int'(POLL);

    typedef struct packed {
        logic [1:0] ack;
        logic       to;
        logic [7:0] rdata;
    } exp_t;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [1:0] req      = 2'b00;
    logic [1:0] op       = 2'b00;
    logic [7:0] wdata0   = 8'h00;
    logic [7:0] wdata1   = 8'h00;
    logic [1:0] ack;
    logic       timeout;
    logic [7:0] rdata;
    logic       ser_A, ser_CE, ser_WREN, ser_REN;
    logic [7:0] ser_wdata;
    logic [7:0] ser_rdata = 8'h00;
    logic       err_tx_ovw, err_rx_ovw;
    logic       err_clr   = 1'b0;

    logic [7:0] per_status = 8'h00;
    logic [7:0] per_data   = 8'h00;
    logic [7:0] r_p1       = 8'h00;
    logic [7:0] last_wbyte = 8'h00;
    logic [7:0] last_rd    = 8'h00;
    logic       ce_d1 = 1'b0, ce_d2 = 1'b0;
    int         n_stat = 0, n_drd = 0, n_dwr = 0, n_viol = 0;
    int         n_chk = 0, n_pass = 0;
    exp_t       q[$];
    exp_t       e;

    always #5 clk = ~clk;

    serial_host_ctrl #(.POLL_LIMIT(POLL), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .op         (op),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack        (ack),
        .timeout    (timeout),
        .rdata      (rdata),
        .ser_A      (ser_A),
        .ser_CE     (ser_CE),
        .ser_WREN   (ser_WREN),
        .ser_REN    (ser_REN),
        .ser_wdata  (ser_wdata),
        .ser_rdata  (ser_rdata),
        .err_tx_ovw (err_tx_ovw),
        .err_rx_ovw (err_rx_ovw),
        .err_clr    (err_clr)
    );

    // Peripheral: registered read bus, data visible two cycles after the REN strobe
    always @(posedge clk) begin
        if (ser_CE && ser_REN) r_p1 <= ser_A ? per_status : per_data;
        ser_rdata <= r_p1;
        if (ser_CE && ser_REN && ser_A)  n_stat <= n_stat + 1;
        if (ser_CE && ser_REN && !ser_A) n_drd  <= n_drd + 1;
        if (ser_CE && ser_WREN && !ser_A) begin
            n_dwr      <= n_dwr + 1;
            last_wbyte <= ser_wdata;
        end
        if ((ser_CE && (ce_d1 || ce_d2)) || ((ser_REN || ser_WREN) && !ser_CE) ||
            (ser_WREN && ser_A) || (ser_REN && ser_WREN))
            n_viol <= n_viol + 1;
        ce_d1 <= ser_CE;
        ce_d2 <= ce_d1;
    end

    task automatic wait_ack(output int cyc, output logic [1:0] av);
        cyc = -1;
        av  = 2'b00;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                cyc = i;
                av  = ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 2'b00;
        repeat (3) @(negedge clk);
        n_chk++; if (ack !== 2'b00) $display("FAIL reset_ack got=%b exp=00", ack); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else n_pass++;
        n_chk++; if (rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", rdata); else n_pass++;
        n_chk++; if (ser_A !== 1'b1) $display("FAIL reset_ser_A got=%b exp=1", ser_A); else n_pass++;
        n_chk++; if ({ser_CE, ser_REN, ser_WREN} !== 3'b000) $display("FAIL reset_strobes got=%b exp=000", {ser_CE, ser_REN, ser_WREN}); else n_pass++;
        n_chk++; if (ser_wdata !== 8'h00) $display("FAIL reset_ser_wdata got=%h exp=00", ser_wdata); else n_pass++;
        n_chk++; if ({err_tx_ovw, err_rx_ovw} !== 2'b00) $display("FAIL reset_err got=%b exp=00", {err_tx_ovw, err_rx_ovw}); else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (ser_CE !== 1'b0) $display("FAIL idle_no_strobe got=%b exp=0", ser_CE); else n_pass++;
    endtask

    task automatic test_write();
        int cyc, s0, w0;
        logic [1:0] av;
        per_status = 8'h14;
        wdata0     = 8'h5A;
        op[0]      = OP_WR;
        s0 = n_stat; w0 = n_dwr;
        e = '{ack: 2'b01, to: 1'b0, rdata: last_rd}; q.push_back(e);
        req[0] = 1'b1;
        wait_ack(cyc, av);
        req[0] = 1'b0;
        n_chk++; if (cyc != WR_LAT) $display("FAIL write_latency got=%0d exp=%0d", cyc, WR_LAT); else n_pass++;
        if (q.size() == 0) begin n_chk++; $display("FAIL write_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL write_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        n_chk++; if (n_dwr - w0 != 1) $display("FAIL write_wren_count got=%0d exp=1", n_dwr - w0); else n_pass++;
        n_chk++; if (last_wbyte !== 8'h5A) $display("FAIL write_byte got=%h exp=5a", last_wbyte); else n_pass++;
        n_chk++; if (n_stat - s0 != 1) $display("FAIL write_polls got=%0d exp=1", n_stat - s0); else n_pass++;
        @(negedge clk);
        n_chk++; if (ack !== 2'b00) $display("FAIL write_ack_pulse got=%b exp=00", ack); else n_pass++;
    endtask

    task automatic test_read();
        int cyc, r0, w0;
        logic [1:0] av;
        per_status = 8'h08;
        per_data   = 8'hC3;
        op[1]      = OP_RD;
        r0 = n_drd; w0 = n_dwr;
        e = '{ack: 2'b10, to: 1'b0, rdata: 8'hC3}; q.push_back(e);
        last_rd = 8'hC3;
        req[1] = 1'b1;
        wait_ack(cyc, av);
        req[1] = 1'b0;
        n_chk++; if (cyc != RD_LAT) $display("FAIL read_latency got=%0d exp=%0d", cyc, RD_LAT); else n_pass++;
        if (q.size() == 0) begin n_chk++; $display("FAIL read_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL read_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        n_chk++; if (n_drd - r0 != 1 || n_dwr != w0) $display("FAIL read_strobes got rd=%0d wr=%0d exp rd=1 wr=0", n_drd - r0, n_dwr - w0); else n_pass++;
        @(negedge clk);
        n_chk++; if (rdata !== 8'hC3) $display("FAIL read_hold got=%h exp=c3", rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc, s0, r0, w0;
        logic [1:0] av;
        per_status = 8'h10;
        op[1]      = OP_RD;
        s0 = n_stat; r0 = n_drd; w0 = n_dwr;
        e = '{ack: 2'b10, to: 1'b1, rdata: last_rd}; q.push_back(e);
        req[1] = 1'b1;
        wait_ack(cyc, av);
        req[1] = 1'b0;
        n_chk++; if (cyc != TO_LAT) $display("FAIL timeout_latency got=%0d exp=%0d", cyc, TO_LAT); else n_pass++;
        if (q.size() == 0) begin n_chk++; $display("FAIL timeout_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL timeout_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        n_chk++; if (n_stat - s0 != int'(POLL)) $display("FAIL timeout_polls got=%0d exp=%0d", n_stat - s0, POLL); else n_pass++;
        n_chk++; if (n_drd != r0 || n_dwr != w0) $display("FAIL timeout_data_strobe got rd=%0d wr=%0d exp 0 0", n_drd - r0, n_dwr - w0); else n_pass++;
        @(negedge clk);
        n_chk++; if (timeout !== 1'b0) $display("FAIL timeout_pulse got=%b exp=0", timeout); else n_pass++;
    endtask

    task automatic test_req_drop();
        int cyc;
        logic [1:0] av;
        per_status = 8'h14;
        wdata1     = 8'h42;
        op[1]      = OP_WR;
        e = '{ack: 2'b10, to: 1'b0, rdata: last_rd}; q.push_back(e);
        req[1] = 1'b1;
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        wait_ack(cyc, av);
        n_chk++; if (cyc < 0 || cyc + 2 != WR_LAT) $display("FAIL drop_latency got=%0d exp=%0d", cyc + 2, WR_LAT); else n_pass++;
        if (q.size() == 0) begin n_chk++; $display("FAIL drop_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL drop_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        n_chk++; if (last_wbyte !== 8'h42) $display("FAIL drop_byte got=%h exp=42", last_wbyte); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, r0, w0;
        logic [1:0] av;
        per_status = 8'h0C;
        per_data   = 8'h77;
        wdata0     = 8'h11;
        op         = 2'b10;
        r0 = n_drd; w0 = n_dwr;
        e = '{ack: 2'b01, to: 1'b0, rdata: last_rd}; q.push_back(e);
        for (int k = 0; k < 3; k++) begin
            e = '{ack: (k % 2 == 0) ? 2'b10 : 2'b01, to: 1'b0, rdata: 8'h77};
            q.push_back(e);
        end
        last_rd = 8'h77;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc, av);
            if (k == 3) req = 2'b00;
            if (q.size() == 0) begin n_chk++; $display("FAIL b2b_sb queue empty k=%0d", k); end
            else begin
                e = q.pop_front();
                n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL b2b_sb k=%0d got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", k, av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
            end
            @(negedge clk);
            n_chk++; if (ack !== 2'b00) $display("FAIL b2b_pulse k=%0d got=%b exp=00", k, ack); else n_pass++;
        end
        req = 2'b00;
        n_chk++; if (n_dwr - w0 != 2 || n_drd - r0 != 2) $display("FAIL b2b_strobes got wr=%0d rd=%0d exp 2 2", n_dwr - w0, n_drd - r0); else n_pass++;
        n_chk++; if (last_wbyte !== 8'h11) $display("FAIL b2b_byte got=%h exp=11", last_wbyte); else n_pass++;
    endtask

    task automatic test_err_sticky();
        int cyc;
        logic [1:0] av;
        bit seen;
        per_status = 8'h16;
        wdata0     = 8'hA5;
        op[0]      = OP_WR;
        e = '{ack: 2'b01, to: 1'b0, rdata: last_rd}; q.push_back(e);
        req[0] = 1'b1;
        wait_ack(cyc, av);
        req[0] = 1'b0;
        if (q.size() == 0) begin n_chk++; $display("FAIL err_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL err_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        n_chk++; if ({err_tx_ovw, err_rx_ovw} !== 2'b01) $display("FAIL err_rx_set got=%b exp=01", {err_tx_ovw, err_rx_ovw}); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (err_rx_ovw !== 1'b1) $display("FAIL err_rx_sticky got=%b exp=1", err_rx_ovw); else n_pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        n_chk++; if ({err_tx_ovw, err_rx_ovw} !== 2'b00) $display("FAIL err_clear got=%b exp=00", {err_tx_ovw, err_rx_ovw}); else n_pass++;

        // TX overwrite sample coinciding with a clear pulse
        per_status = 8'h15;
        wdata1     = 8'h3C;
        op[1]      = OP_WR;
        e = '{ack: 2'b10, to: 1'b0, rdata: last_rd}; q.push_back(e);
        req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ser_CE && ser_REN && ser_A) seen = 1'b1;
        end
        n_chk++; if (!seen) $display("FAIL err_stat_strobe got=0 exp=1"); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_chk++; if (err_tx_ovw !== 1'b1) $display("FAIL err_set_wins got=%b exp=1", err_tx_ovw); else n_pass++;
        wait_ack(cyc, av);
        req[1] = 1'b0;
        if (q.size() == 0) begin n_chk++; $display("FAIL err2_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL err2_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [1:0] av;
        bit seen, bad;
        per_status = 8'h08;
        per_data   = 8'hE7;
        op[0]      = OP_RD;
        req[0]     = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (ser_CE && ser_REN && !ser_A) seen = 1'b1;
        end
        n_chk++; if (!seen) $display("FAIL rstmid_data_strobe got=0 exp=1"); else n_pass++;
        @(negedge clk);
        reset_n = 1'b0;
        req     = 2'b00;
        #1;
        n_chk++; if ({ser_CE, ser_REN, ser_WREN} !== 3'b000) $display("FAIL rstmid_strobes got=%b exp=000", {ser_CE, ser_REN, ser_WREN}); else n_pass++;
        n_chk++; if (ser_A !== 1'b1) $display("FAIL rstmid_ser_A got=%b exp=1", ser_A); else n_pass++;
        n_chk++; if ({err_tx_ovw, err_rx_ovw} !== 2'b00) $display("FAIL rstmid_err got=%b exp=00", {err_tx_ovw, err_rx_ovw}); else n_pass++;
        n_chk++; if (rdata !== 8'h00) $display("FAIL rstmid_rdata got=%h exp=00", rdata); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_rd = 8'h00;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 2'b00 || ser_CE !== 1'b0) bad = 1'b1;
        end
        n_chk++; if (bad) $display("FAIL rstmid_idle got=activity exp=idle"); else n_pass++;

        per_status = 8'h14;
        wdata0     = 8'h99;
        op[0]      = OP_WR;
        e = '{ack: 2'b01, to: 1'b0, rdata: last_rd}; q.push_back(e);
        req[0] = 1'b1;
        wait_ack(cyc, av);
        req[0] = 1'b0;
        n_chk++; if (cyc != WR_LAT) $display("FAIL rstmid_latency got=%0d exp=%0d", cyc, WR_LAT); else n_pass++;
        if (q.size() == 0) begin n_chk++; $display("FAIL rstmid_sb queue empty"); end
        else begin
            e = q.pop_front();
            n_chk++; if ({av, timeout, rdata} !== e) $display("FAIL rstmid_sb got ack=%b to=%b rd=%h exp ack=%b to=%b rd=%h", av, timeout, rdata, e.ack, e.to, e.rdata); else n_pass++;
        end
        n_chk++; if (last_wbyte !== 8'h99) $display("FAIL rstmid_byte got=%h exp=99", last_wbyte); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_req_drop();
        test_back_to_back();
        test_err_sticky();
        test_reset_mid();
        n_chk++; if (n_viol != 0) $display("FAIL strobe_rules got=%0d exp=0", n_viol); else n_pass++;
        n_chk++; if (q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
